// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the i2c_master controller
package i2c_pkg;

  // Controller sequencing states.
  typedef enum logic [3:0] {
    IDLE,
    START,
    BYTE,
    ACK,
    RSTART,
    READ,
    MACK,
    STOP,
    DONE
  } i2c_state_e;

  // Level of SDA during an acknowledge slot.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Layout of the address byte: {addr[6:0], rw}.
  localparam int I2C_RW_BIT   = 0;
  localparam int I2C_ADDR_LSB = 1;
  localparam int I2C_ADDR_MSB = 7;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // Address of the on-chip slave used for loopback self-test.
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h70;

  // Build the first byte of a transfer from a 7-bit address and direction.
  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic dir);
    logic [7:0] b;
    b = 8'h00;
    b[I2C_ADDR_MSB:I2C_ADDR_LSB] = dev;
    b[I2C_RW_BIT] = dir;
    return b;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - SCL quarter-period tick generator with hold and clear
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  // Count CLK_DIV cycles per quarter; hold freezes the count, clear parks it at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (!hold_i) begin
      cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  // Quarter counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clr_i && !hold_i && (cnt_q == LAST);

endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-master I2C register write/read controller (option: I2C_MASTER_STRETCH_EN)
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  input  logic       scl_i
);

  i2c_state_e state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       ack_q, ack_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic       nack_q, nack_d;
  logic       done_q, done_d;
  logic [7:0] rdata_q, rdata_d;
  logic       scl_oe_c, sda_oe_c;

  logic tick, hold, slot_end, samp, qclr;

  assign qclr     = (state_q == IDLE) || (state_q == DONE);
  assign slot_end = tick && (phase_q == 2'd3);
  assign samp     = tick && (phase_q == 2'd2);

`ifdef I2C_MASTER_STRETCH_EN
  // A slave holding SCL low while we have released it stalls the high phase.
  assign hold = (phase_q == 2'd1) && !scl_oe_c && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold = 1'b0;
`endif

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (qclr),
    .hold_i (hold),
    .tick_o (tick)
  );

  // Next-state sequencing and pad drive for each slot and quarter.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    ack_d    = ack_q;
    rw_d     = rw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    nack_d   = nack_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    scl_oe_c = 1'b0;
    sda_oe_c = 1'b0;

    if (tick) begin
      phase_d = phase_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          phase_d = 2'd0;
          rw_d    = rw;
          dev_d   = dev_addr;
          reg_d   = reg_addr;
          wdata_d = wdata;
          nack_d  = 1'b0;
        end
      end
      START, RSTART: begin
        scl_oe_c = (phase_q == 2'd3);
        sda_oe_c = (phase_q >= 2'd2);
        if (slot_end) begin
          state_d = BYTE;
          bit_d   = 3'd7;
          if (state_q == START) begin
            tx_d   = addr_byte(dev_q, I2C_RW_WRITE);
            byte_d = 2'd0;
          end else begin
            tx_d   = addr_byte(dev_q, I2C_RW_READ);
            byte_d = 2'd2;
          end
        end
      end
      BYTE: begin
        scl_oe_c = (phase_q == 2'd0) || (phase_q == 2'd3);
        sda_oe_c = !tx_q[7];
        if (slot_end) begin
          tx_d = {tx_q[6:0], 1'b0};
          if (bit_q == 3'd0) begin
            state_d = ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ACK: begin
        scl_oe_c = (phase_q == 2'd0) || (phase_q == 2'd3);
        if (samp) begin
          ack_d = sda_i;
        end
        if (slot_end) begin
          if (ack_q == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            case (byte_q)
              2'd0: begin
                state_d = BYTE;
                tx_d    = reg_q;
                bit_d   = 3'd7;
                byte_d  = 2'd1;
              end
              2'd1: begin
                if (rw_q) begin
                  state_d = RSTART;
                end else begin
                  state_d = BYTE;
                  tx_d    = wdata_q;
                  bit_d   = 3'd7;
                  byte_d  = 2'd2;
                end
              end
              default: begin
                if (rw_q) begin
                  state_d = READ;
                  bit_d   = 3'd7;
                end else begin
                  state_d = STOP;
                end
              end
            endcase
          end
        end
      end
      READ: begin
        scl_oe_c = (phase_q == 2'd0) || (phase_q == 2'd3);
        if (samp) begin
          rx_d = {rx_q[6:0], sda_i};
        end
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = MACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      MACK: begin
        // SDA stays released: the master NACKs the single read byte.
        scl_oe_c = (phase_q == 2'd0) || (phase_q == 2'd3);
        if (slot_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        scl_oe_c = (phase_q == 2'd0);
        sda_oe_c = (phase_q <= 2'd1);
        if (slot_end) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (rw_q && !nack_q) begin
          rdata_d = rx_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      ack_q   <= 1'b0;
      rw_q    <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ack_q   <= ack_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign nack   = nack_q;
  assign rdata  = rdata_q;
  assign scl_oe = scl_oe_c;
  assign sda_oe = sda_oe_c;

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - directed self-checking bench for i2c_master with a bus-level slave at 0x70
module tb_i2c_master;

  localparam int CD = 4;
`ifdef I2C_MASTER_STRETCH_EN
  localparam int STRETCH_EXTRA = 20;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = 7'h00;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       ready, done, nack;
  logic [7:0] rdata;
  logic       scl_oe, sda_oe, sda_i, scl_i;

  logic stretch = 1'b0;
  logic model_clr = 1'b1;

  int errors = 0;
  int checks = 0;

  // slave model state
  logic       s_drive;
  logic       p_scl, p_sda;
  logic [2:0] mode;
  logic [3:0] bitc;
  logic [1:0] byte_idx;
  logic       rd;
  logic [7:0] shreg, txb, ptr;
  logic [7:0] mem [256];
  int         starts, stops, rstarts;
  logic       in_txn;

  assign scl_i = ~(scl_oe | stretch);
  assign sda_i = ~(sda_oe | s_drive);

  always #5 clk = ~clk;

  i2c_master #(.CLK_DIV(CD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rw       (rw),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .nack     (nack),
    .rdata    (rdata),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .sda_i    (sda_i),
    .scl_i    (scl_i)
  );

  // Bus-level slave at 0x70: register pointer, write into mem, read from mem.
  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      s_drive <= 1'b0; p_scl <= 1'b1; p_sda <= 1'b1; mode <= 3'd0;
      bitc <= 4'd0; byte_idx <= 2'd0; rd <= 1'b0; shreg <= 8'h00;
      txb <= 8'h00; ptr <= 8'h00; starts <= 0; stops <= 0; rstarts <= 0;
      in_txn <= 1'b0;
    end else begin
      p_scl <= scl_i;
      p_sda <= sda_i;
      if (p_scl && scl_i && p_sda && !sda_i) begin
        if (in_txn) rstarts <= rstarts + 1;
        starts <= starts + 1;
        in_txn <= 1'b1; mode <= 3'd1; bitc <= 4'd0; byte_idx <= 2'd0; s_drive <= 1'b0;
      end else if (p_scl && scl_i && !p_sda && sda_i) begin
        stops <= stops + 1;
        in_txn <= 1'b0; mode <= 3'd0; s_drive <= 1'b0;
      end else if (!p_scl && scl_i) begin
        if (mode == 3'd1) begin
          shreg <= {shreg[6:0], sda_i};
          bitc  <= bitc + 4'd1;
        end
      end else if (p_scl && !scl_i) begin
        case (mode)
          3'd1: begin
            if (bitc == 4'd8) begin
              bitc <= 4'd0;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd0) begin
                if (shreg[7:1] == 7'h70) begin
                  s_drive <= 1'b1; mode <= 3'd2; rd <= shreg[0];
                end else begin
                  mode <= 3'd0;
                end
              end else begin
                if (byte_idx == 2'd1) ptr <= shreg;
                else begin mem[ptr] <= shreg; ptr <= ptr + 8'd1; end
                s_drive <= 1'b1; mode <= 3'd2;
              end
            end
          end
          3'd2: begin
            if (rd) begin
              mode <= 3'd3; txb <= mem[ptr]; s_drive <= ~mem[ptr][7]; bitc <= 4'd1;
            end else begin
              s_drive <= 1'b0; mode <= 3'd1;
            end
          end
          3'd3: begin
            if (bitc == 4'd8) begin
              s_drive <= 1'b0; mode <= 3'd4;
            end else begin
              s_drive <= ~txb[4'd7 - bitc];
              bitc <= bitc + 4'd1;
            end
          end
          3'd4: mode <= 3'd0;
          default: mode <= 3'd0;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic r, input logic [6:0] d,
                       input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clk);
    chk({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
    rw = r; dev_addr = d; reg_addr = ra; wdata = wd; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_ready_fell"}, {31'd0, ready}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_ready_with_done"}, {31'd0, ready}, 32'd1);
    lat = n;
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int hits;
    hits = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) hits++;
    end
    chk(tag, hits, 0);
  endtask

  initial begin
    int lat, s0, p0, r0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_nack", {31'd0, nack}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    rst_n = 1'b1;
    model_clr = 1'b0;
    repeat (4) @(negedge clk);

    // write 0x03 <- 0xA5
    issue("wr", 1'b0, 7'h70, 8'h03, 8'hA5);
    wait_done("wr", 2000, lat);
    chk("wr_latency", lat, 116 * CD + 1);
    chk("wr_nack", {31'd0, nack}, 32'd0);
    chk("wr_mem3", {24'd0, mem[3]}, 32'hA5);

    // read 0x03 back, with repeated START
    r0 = rstarts;
    issue("rd", 1'b1, 7'h70, 8'h03, 8'h00);
    wait_done("rd", 2000, lat);
    chk("rd_latency", lat, 156 * CD + 1);
    chk("rd_nack", {31'd0, nack}, 32'd0);
    chk("rd_rdata", {24'd0, rdata}, 32'hA5);
    chk("rd_rstart", rstarts - r0, 1);

    // absent device: NACK on address byte
    p0 = stops;
    issue("nk", 1'b0, 7'h71, 8'h03, 8'h5A);
    wait_done("nk", 2000, lat);
    chk("nk_latency", lat, 44 * CD + 1);
    chk("nk_nack", {31'd0, nack}, 32'd1);
    chk("nk_stop", stops - p0, 1);
    chk("nk_rdata_kept", {24'd0, rdata}, 32'hA5);
    chk("nk_mem3_kept", {24'd0, mem[3]}, 32'hA5);

    // start while busy is ignored
    s0 = starts;
    p0 = stops;
    issue("ig", 1'b0, 7'h70, 8'h04, 8'h3C);
    fork
      begin
        repeat (30) @(negedge clk);
        rw = 1'b0; dev_addr = 7'h70; reg_addr = 8'h05; wdata = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done("ig", 2000, lat);
    join
    chk("ig_latency", lat, 116 * CD + 1);
    no_done("ig_no_second_done", 600);
    chk("ig_starts", starts - s0, 1);
    chk("ig_stops", stops - p0, 1);
    chk("ig_mem4", {24'd0, mem[4]}, 32'h3C);
    chk("ig_mem5", {24'd0, mem[5]}, 32'h00);

    // synchronous reset in the middle of the address byte
    p0 = stops;
    issue("rs", 1'b0, 7'h70, 8'h07, 8'h11);
    repeat (66) @(posedge clk);
    @(negedge clk);
    chk("rs_pre_scl_oe", {31'd0, scl_oe}, 32'd1);
    chk("rs_pre_sda_oe", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rs_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rs_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rs_ready", {31'd0, ready}, 32'd1);
    chk("rs_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done("rs_no_done", 300);
    chk("rs_no_stop", stops - p0, 0);

    // slave stretches SCL in bit 3 of the data byte
    issue("st", 1'b0, 7'h70, 8'h06, 8'h77);
    fork
      begin
        repeat (372) @(posedge clk);
        @(negedge clk);
        stretch = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        stretch = 1'b0;
      end
      wait_done("st", 3000, lat);
    join
    chk("st_latency", lat, 116 * CD + 1 + STRETCH_EXTRA);
`ifdef I2C_MASTER_STRETCH_EN
    chk("st_nack", {31'd0, nack}, 32'd0);
    chk("st_mem6", {24'd0, mem[6]}, 32'h77);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
